// File: rtl/joybus_rx_decoder.sv
// Joybus line receiver: synchronises the pad, decodes bits by low/high period
// comparison, packs them MSB-first into bytes and delimits frames by idle time.
module joybus_rx_decoder #(
  parameter int CNT_WIDTH      = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int IDLE_CYCLES    = 96,
  parameter int MIN_PULSE      = 2,
  parameter int BYTE_CNT_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx_enable,
  input  logic                      data,
  output logic                      bit_valid,
  output logic                      bit_value,
  output logic                      byte_valid,
  output logic [7:0]                byte_data,
  output logic [BYTE_CNT_WIDTH-1:0] byte_count,
  output logic                      frame_done,
  output logic                      frame_partial,
  output logic                      err_glitch,
  output logic                      busy
);

  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]      IDLE_CNT = CNT_WIDTH'(IDLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0]      MIN_CNT  = CNT_WIDTH'(MIN_PULSE);
  localparam logic [BYTE_CNT_WIDTH-1:0] BYTE_MAX = '1;
  localparam logic [BYTE_CNT_WIDTH-1:0] BYTE_ONE = BYTE_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOW     = 2'd1,
    ST_HIGH    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      prev_q;
  logic                      data_s;
  logic                      fall_s;
  logic                      rise_s;
  logic                      decoded_bit;

  state_t                    state_q,         state_d;
  logic [CNT_WIDTH-1:0]      low_cnt_q,       low_cnt_d;
  logic [CNT_WIDTH-1:0]      high_cnt_q,      high_cnt_d;
  logic [CNT_WIDTH-1:0]      low_lat_q,       low_lat_d;
  logic [7:0]                shift_q,         shift_d;
  logic [2:0]                bit_cnt_q,       bit_cnt_d;
  logic                      bit_valid_q,     bit_valid_d;
  logic                      bit_value_q,     bit_value_d;
  logic                      byte_valid_q,    byte_valid_d;
  logic [7:0]                byte_data_q,     byte_data_d;
  logic [BYTE_CNT_WIDTH-1:0] byte_count_q,    byte_count_d;
  logic                      frame_done_q,    frame_done_d;
  logic                      frame_partial_q, frame_partial_d;
  logic                      err_glitch_q,    err_glitch_d;
  logic                      busy_q;

  assign data_s      = sync_q[SYNC_STAGES-1];
  assign fall_s      = prev_q & ~data_s;
  assign rise_s      = ~prev_q & data_s;
  // A tie between low and high time decodes as 1.
  assign decoded_bit = (low_lat_q > high_cnt_q) ? 1'b0 : 1'b1;

  always_comb begin
    state_d         = state_q;
    low_cnt_d       = low_cnt_q;
    high_cnt_d      = high_cnt_q;
    low_lat_d       = low_lat_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    bit_valid_d     = 1'b0;
    bit_value_d     = bit_value_q;
    byte_valid_d    = 1'b0;
    byte_data_d     = byte_data_q;
    byte_count_d    = byte_count_q;
    frame_done_d    = 1'b0;
    frame_partial_d = frame_partial_q;
    err_glitch_d    = 1'b0;

    if (!rx_enable) begin
      state_d    = ST_IDLE;
      low_cnt_d  = '0;
      high_cnt_d = '0;
      low_lat_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall_s) begin
            state_d         = ST_LOW;
            low_cnt_d       = CNT_ONE;
            shift_d         = 8'h00;
            bit_cnt_d       = 3'd0;
            byte_count_d    = '0;
            frame_partial_d = 1'b0;
          end
        end
        ST_LOW: begin
          if (rise_s) begin
            high_cnt_d = CNT_ONE;
            if (low_cnt_q < MIN_CNT) begin
              err_glitch_d = 1'b1;
              state_d      = ST_RECOVER;
            end else begin
              low_lat_d = low_cnt_q;
              state_d   = ST_HIGH;
            end
          end else if (!data_s && (low_cnt_q != CNT_MAX)) begin
            low_cnt_d = low_cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (fall_s && (high_cnt_q < MIN_CNT)) begin
            err_glitch_d = 1'b1;
            high_cnt_d   = '0;
            state_d      = ST_RECOVER;
          end else if (fall_s) begin
            bit_valid_d = 1'b1;
            bit_value_d = decoded_bit;
            shift_d     = {shift_q[6:0], decoded_bit};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_valid_d = 1'b1;
              byte_data_d  = {shift_q[6:0], decoded_bit};
              if (byte_count_q != BYTE_MAX) begin
                byte_count_d = byte_count_q + BYTE_ONE;
              end
            end
            low_cnt_d = CNT_ONE;
            state_d   = ST_LOW;
          end else if (high_cnt_q == IDLE_CNT) begin
            // The last low/high pair was the stop bit; it carries no data.
            frame_done_d    = 1'b1;
            frame_partial_d = (bit_cnt_q != 3'd0);
            low_cnt_d       = '0;
            high_cnt_d      = '0;
            state_d         = ST_IDLE;
          end else if (data_s && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + CNT_ONE;
          end
        end
        ST_RECOVER: begin
          if (!data_s) begin
            high_cnt_d = '0;
          end else if (high_cnt_q == IDLE_CNT) begin
            low_cnt_d  = '0;
            high_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            high_cnt_d = high_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          low_cnt_d  = '0;
          high_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q          <= '1;
      prev_q          <= 1'b1;
      state_q         <= ST_IDLE;
      low_cnt_q       <= '0;
      high_cnt_q      <= '0;
      low_lat_q       <= '0;
      shift_q         <= 8'h00;
      bit_cnt_q       <= 3'd0;
      bit_valid_q     <= 1'b0;
      bit_value_q     <= 1'b1;
      byte_valid_q    <= 1'b0;
      byte_data_q     <= 8'h00;
      byte_count_q    <= '0;
      frame_done_q    <= 1'b0;
      frame_partial_q <= 1'b0;
      err_glitch_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      sync_q          <= {sync_q[SYNC_STAGES-2:0], data};
      prev_q          <= data_s;
      state_q         <= state_d;
      low_cnt_q       <= low_cnt_d;
      high_cnt_q      <= high_cnt_d;
      low_lat_q       <= low_lat_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      bit_valid_q     <= bit_valid_d;
      bit_value_q     <= bit_value_d;
      byte_valid_q    <= byte_valid_d;
      byte_data_q     <= byte_data_d;
      byte_count_q    <= byte_count_d;
      frame_done_q    <= frame_done_d;
      frame_partial_q <= frame_partial_d;
      err_glitch_q    <= err_glitch_d;
      busy_q          <= (state_d != ST_IDLE);
    end
  end

  assign bit_valid     = bit_valid_q;
  assign bit_value     = bit_value_q;
  assign byte_valid    = byte_valid_q;
  assign byte_data     = byte_data_q;
  assign byte_count    = byte_count_q;
  assign frame_done    = frame_done_q;
  assign frame_partial = frame_partial_q;
  assign err_glitch    = err_glitch_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_joybus_rx_decoder.sv
// Scoreboard bench for joybus_rx_decoder: expected bits, bytes and frame ends
// are queued as the line is driven and matched as the decoder reports them.
module tb_joybus_rx_decoder;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_enable;
  logic       data;
  logic       bit_valid;
  logic       bit_value;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [5:0] byte_count;
  logic       frame_done;
  logic       frame_partial;
  logic       err_glitch;
  logic       busy;

  joybus_rx_decoder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .rx_enable(rx_enable), .data(data),
    .bit_valid(bit_valid), .bit_value(bit_value), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_count(byte_count), .frame_done(frame_done),
    .frame_partial(frame_partial), .err_glitch(err_glitch), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int bv_cyc = 0;
  int glitch_seen = 0;

  logic       exp_bits[$];
  logic [7:0] exp_bytes[$];
  logic       exp_part[$];
  int         exp_cnt[$];

  logic [7:0] m_shift;
  int         m_bits;
  int         m_bytes;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: match every output pulse against the head of its queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bit_valid) begin
        bv_cyc = cyc;
        if (exp_bits.size() == 0) check_eq("bit_unexpected", 32'd1, 32'd0);
        else check_eq("bit_value", {31'd0, bit_value}, {31'd0, exp_bits.pop_front()});
      end
      if (byte_valid) begin
        if (exp_bytes.size() == 0) check_eq("byte_unexpected", 32'd1, 32'd0);
        else check_eq("byte_data", {24'd0, byte_data}, {24'd0, exp_bytes.pop_front()});
      end
      if (frame_done) begin
        if (exp_part.size() == 0) check_eq("frame_unexpected", 32'd1, 32'd0);
        else begin
          check_eq("frame_partial", {31'd0, frame_partial}, {31'd0, exp_part.pop_front()});
          check_eq("frame_byte_count", {26'd0, byte_count}, exp_cnt.pop_front());
        end
      end
      if (err_glitch) glitch_seen++;
    end
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (data && !v) last_fall_cyc = cyc;
      data = v;
    end
  endtask

  task automatic push_bit(input logic b);
    exp_bits.push_back(b);
    m_shift = {m_shift[6:0], b};
    m_bits++;
    if (m_bits % 8 == 0) begin
      exp_bytes.push_back(m_shift);
      m_bytes++;
    end
  endtask

  task automatic start_frame();
    m_bits  = 0;
    m_bytes = 0;
    m_shift = 8'h00;
  endtask

  task automatic send_bit(input logic b, input logic push);
    if (b) begin
      drive(1'b0, 10);
      drive(1'b1, 30);
    end else begin
      drive(1'b0, 30);
      drive(1'b1, 10);
    end
    if (push) push_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b1);
  endtask

  task automatic end_frame();
    exp_part.push_back((m_bits % 8) != 0);
    exp_cnt.push_back((m_bytes > 63) ? 63 : m_bytes);
    drive(1'b0, 10);
    drive(1'b1, 120);
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_bits_left"}, exp_bits.size(), 32'd0);
    check_eq({tag, "_bytes_left"}, exp_bytes.size(), 32'd0);
    check_eq({tag, "_frames_left"}, exp_part.size(), 32'd0);
  endtask

  initial begin
    int g0;
    reset_n   = 1'b0;
    rx_enable = 1'b1;
    data      = 1'b1;
    start_frame();

    // Reset with a toggling line
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      data = ~data;
    end
    check_eq("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    check_eq("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_err_glitch", {31'd0, err_glitch}, 32'd0);
    check_eq("rst_bit_value", {31'd0, bit_value}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_byte_count", {26'd0, byte_count}, 32'd0);
    @(negedge clk);
    data    = 1'b1;
    reset_n = 1'b1;
    drive(1'b1, 6);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Single-bit decode: 1, 0, tie -> 1, plus latency from line edge
    start_frame();
    drive(1'b0, 10);
    drive(1'b1, 30);
    push_bit(1'b1);
    drive(1'b0, 30);
    check_eq("bit_latency", bv_cyc - last_fall_cyc, SYNC + 1);
    drive(1'b1, 10);
    push_bit(1'b0);
    drive(1'b0, 20);
    drive(1'b1, 20);
    push_bit(1'b1);
    end_frame();
    check_drained("bits");

    // Two full bytes
    start_frame();
    send_byte(8'hA5);
    send_byte(8'h3C);
    end_frame();
    check_drained("bytes");
    check_eq("byte_count_hold", {26'd0, byte_count}, 32'd2);
    check_eq("busy_after_frame", {31'd0, busy}, 32'd0);

    // Partial frame: 11 bits
    start_frame();
    send_byte(8'h5A);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    end_frame();
    check_drained("partial");
    check_eq("partial_count", {26'd0, byte_count}, 32'd1);

    // One-sample high glitch mid-byte, then recovery and a clean frame
    start_frame();
    g0 = glitch_seen;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    drive(1'b0, 10);
    drive(1'b1, 1);
    drive(1'b0, 10);
    drive(1'b1, 50);
    check_eq("glitch_pulses", glitch_seen - g0, 32'd1);
    check_eq("recover_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, 60);
    check_eq("recovered_busy", {31'd0, busy}, 32'd0);
    check_drained("glitch");
    start_frame();
    send_byte(8'h81);
    end_frame();
    check_drained("after_glitch");
    check_eq("after_glitch_count", {26'd0, byte_count}, 32'd1);

    // Abort after 5 bits: the fifth is never decided
    start_frame();
    g0 = glitch_seen;
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b1);
    send_bit(1'b1, 1'b0);
    rx_enable = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 130);
    check_eq("abort_glitch", glitch_seen - g0, 32'd0);
    check_drained("abort");
    rx_enable = 1'b1;
    drive(1'b1, 5);
    start_frame();
    send_byte(8'hC3);
    end_frame();
    check_drained("reenable");
    check_eq("reenable_count", {26'd0, byte_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
